spi_master: RTL and testbench

SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first) that drives sclk, mosi and cs_n, and samples miso. It is the other end of our SPI peripheral, whose MISO line sits behind a tri-state enable buffer. A host strobes start with a data word; the block shifts it out while shifting a response word in. It then pulses done with the received word.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sclk_gen.sv | 59 +++++
 rtl/spi_master.sv | 176 +++++++++++++++++
 tb/tb_spi_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the initiator and by the peripheral-side model.
// Contents:
//   spi_state_e : transfer phases (IDLE, SETUP, TRANSFER, HOLD)
//   CPOL, CPHA  : SPI mode constants (mode 0: clock idles low, sample on leading edge)
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD
    } spi_state_e;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider and edge generator.
// While enable is high, sclk toggles every CLK_DIV clk cycles, starting from the
// idle level. rise_pulse / fall_pulse are high during the clk cycle whose closing
// edge makes sclk rise / fall, so the caller can act on that same clk edge.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   enable       : run the divider; low forces sclk to idle and clears the count
//   sclk         : registered SPI clock
//   rise_pulse   : next clk edge produces a rising sclk edge
//   fall_pulse   : next clk edge produces a falling sclk edge
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    always_comb begin
        wrap      = enable && (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (!enable) begin
            div_cnt_d = '0;
            sclk_d    = CPOL;
        end else if (wrap) begin
            div_cnt_d = '0;
            sclk_d    = ~sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            sclk_q    <= CPOL;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk       = sclk_q;
    assign rise_pulse = wrap && !sclk_q;
    assign fall_pulse = wrap && sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI initiator, mode 0, MSB first.
// A start seen while idle latches tx_data and runs SETUP (cs_n low, sclk idle),
// TRANSFER (DATA_WIDTH sclk periods, shifting mosi out and miso in), then HOLD
// (cs_n still low). Leaving HOLD releases cs_n and pulses done with rx_data.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   start        : transfer request, only looked at while idle
//   tx_data      : word to send, captured on the accepting edge
//   busy         : transfer in progress
//   done         : one-cycle pulse, rx_data freshly updated
//   rx_data      : last received word
//   sclk, mosi   : SPI clock and serial data out (both registered)
//   miso         : serial data in
//   cs_n         : chip select, active low (registered)
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    spi_state_e            state_q, state_d;
    logic [DIV_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic sclk_en;
    logic rise_pulse, fall_pulse;
    logic sample_pulse, shift_pulse;

    assign sclk_en = (state_q == TRANSFER);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (sclk_en),
        .sclk       (sclk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Leading edge samples and trailing edge shifts when CPHA=0.
    assign sample_pulse = (CPHA == 1'b0) ? rise_pulse : fall_pulse;
    assign shift_pulse  = (CPHA == 1'b0) ? fall_pulse : rise_pulse;

    // SETUP waits until the counter reaches CLK_DIV, so it lasts CLK_DIV+1 cycles;
    // with CLK_DIV-cycle TRANSFER half-periods and HOLD this puts done on edge
    // (2*DATA_WIDTH+2)*CLK_DIV+1 after acceptance.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    wait_cnt_d = '0;
                    bit_cnt_d  = '0;
                    mosi_d     = tx_data[DATA_WIDTH-1];
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                if (wait_cnt_q == DIV_W'(CLK_DIV)) begin
                    wait_cnt_d = '0;
                    state_d    = TRANSFER;
                end else begin
                    wait_cnt_d = wait_cnt_q + DIV_W'(1);
                end
            end

            TRANSFER: begin
                if (sample_pulse) begin
                    rx_shift_d = DATA_WIDTH'({rx_shift_q, miso});
                end
                if (shift_pulse) begin
                    tx_shift_d = tx_shift_q << 1;
                    // The last trailing edge parks mosi low and ends the transfer.
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        mosi_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = HOLD;
                    end else begin
                        mosi_d    = tx_shift_d[DATA_WIDTH-1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            HOLD: begin
                if (wait_cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    wait_cnt_d = '0;
                    cs_n_d     = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    rx_data_d  = rx_shift_q;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: instance A (DATA_WIDTH=8, CLK_DIV=2) and
// instance B (DATA_WIDTH=4, CLK_DIV=1). Expected rx_data and done cycle are
// queued when a start is issued and checked by a monitor whenever done pulses.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rx;
        int          cyc;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];

    // Instance A signals
    logic       a_rst_n, a_start, a_busy, a_done, a_sclk, a_mosi, a_miso, a_csn;
    logic [7:0] a_tx, a_rx;
    logic       a_loop;

    // Instance B signals
    logic       b_rst_n, b_start, b_busy, b_done, b_sclk, b_mosi, b_miso, b_csn;
    logic [3:0] b_tx, b_rx;

    // Responder: presents 0x3C MSB first, next bit on each sclk fall
    logic [7:0] resp_sr = 8'h00;
    always @(negedge a_csn) resp_sr = 8'h3C;
    always @(negedge a_sclk) resp_sr = resp_sr << 1;

    assign a_miso = a_loop ? a_mosi : resp_sr[7];
    assign b_miso = b_mosi;

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (
        .clk     (clk),
        .reset_n (a_rst_n),
        .start   (a_start),
        .tx_data (a_tx),
        .busy    (a_busy),
        .done    (a_done),
        .rx_data (a_rx),
        .sclk    (a_sclk),
        .mosi    (a_mosi),
        .miso    (a_miso),
        .cs_n    (a_csn)
    );

    spi_master #(.DATA_WIDTH(4), .CLK_DIV(1)) dut_b (
        .clk     (clk),
        .reset_n (b_rst_n),
        .start   (b_start),
        .tx_data (b_tx),
        .busy    (b_busy),
        .done    (b_done),
        .rx_data (b_rx),
        .sclk    (b_sclk),
        .mosi    (b_mosi),
        .miso    (b_miso),
        .cs_n    (b_csn)
    );

    // mosi seen on each rising sclk edge of instance A
    logic [7:0] a_rise_log = 8'h00;
    int         a_rises    = 0;
    always @(posedge a_sclk) begin
        a_rise_log = {a_rise_log[6:0], a_mosi};
        a_rises    = a_rises + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called #1 after a clk edge; the next edge accepts the start.
    task automatic applyStimulus(input bit use_b, input logic [7:0] word,
                                 input logic [31:0] rx_exp, input int latency);
        if (!use_b) begin
            a_start = 1'b1;
            a_tx    = word;
        end else begin
            b_start = 1'b1;
            b_tx    = word[3:0];
        end
        @(posedge clk);
        #1;
        if (!use_b) begin
            a_q.push_back('{rx: rx_exp, cyc: cyc + latency});
            a_start = 1'b0;
            a_tx    = ~word;
        end else begin
            b_q.push_back('{rx: rx_exp, cyc: cyc + latency});
            b_start = 1'b0;
            b_tx    = ~word[3:0];
        end
    endtask

    task automatic waitDone(input bit use_b, input int limit);
        int n;
        n = 0;
        while (!(use_b ? b_done : a_done) && n < limit) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        if (!(use_b ? b_done : a_done)) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("[TB] FAIL done_timeout: no done within %0d cycles (instance %s)",
                     limit, use_b ? "B" : "A");
        end
    endtask

    int a_dones = 0;
    int b_dones = 0;

    // Scoreboard monitors
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (a_done) begin
            a_dones = a_dones + 1;
            if (a_q.size() == 0) begin
                vectors     = vectors + 1;
                miscompares = miscompares + 1;
                $display("[TB] FAIL a_unexpected_done: done at cycle %0d, none expected", cyc);
            end else begin
                e = a_q.pop_front();
                checkOutput("a_rx_data", 32'(a_rx), e.rx);
                checkOutput("a_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (b_done) begin
            b_dones = b_dones + 1;
            if (b_q.size() == 0) begin
                vectors     = vectors + 1;
                miscompares = miscompares + 1;
                $display("[TB] FAIL b_unexpected_done: done at cycle %0d, none expected", cyc);
            end else begin
                e = b_q.pop_front();
                checkOutput("b_rx_data", 32'(b_rx), e.rx);
                checkOutput("b_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, d0, low, tog;
        logic prev;

        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        a_tx    = 8'h00;
        b_tx    = 4'h0;
        a_loop  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_cs_n",    32'(a_csn),  32'd1);
        checkOutput("rst_sclk",    32'(a_sclk), 32'd0);
        checkOutput("rst_mosi",    32'(a_mosi), 32'd0);
        checkOutput("rst_busy",    32'(a_busy), 32'd0);
        checkOutput("rst_done",    32'(a_done), 32'd0);
        checkOutput("rst_rx_data", 32'(a_rx),   32'd0);
        checkOutput("rst_b_cs_n",  32'(b_csn),  32'd1);

        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] loopback 0xA5");
        r0 = a_rises;
        applyStimulus(1'b0, 8'hA5, 32'hA5, 37);
        low = 0;
        for (int i = 1; i <= 37; i++) begin
            @(posedge clk);
            #1;
            if (i <= 36 && a_csn == 1'b0) low = low + 1;
            if (i == 37) begin
                checkOutput("t1_cs_n_after_done_edge", 32'(a_csn), 32'd1);
                checkOutput("t1_busy_after_done_edge", 32'(a_busy), 32'd0);
            end
        end
        checkOutput("t1_cs_n_low_cycles", 32'(low), 32'd36);
        checkOutput("t1_sclk_rises", 32'(a_rises - r0), 32'd8);

        $display("[TB] responder 0x3C, tx 0x81");
        a_loop = 1'b0;
        r0 = a_rises;
        applyStimulus(1'b0, 8'h81, 32'h3C, 37);
        waitDone(1'b0, 100);
        checkOutput("t2_mosi_on_rises", 32'(a_rise_log), 32'h81);
        checkOutput("t2_sclk_rises", 32'(a_rises - r0), 32'd8);
        @(posedge clk);
        #1;
        a_loop = 1'b1;

        $display("[TB] start while busy ignored");
        d0 = a_dones;
        r0 = a_rises;
        applyStimulus(1'b0, 8'h66, 32'h66, 37);
        repeat (9) @(posedge clk);
        #1;
        a_start = 1'b1;
        a_tx    = 8'hFF;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_tx    = 8'h00;
        waitDone(1'b0, 100);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("t3_done_count", 32'(a_dones - d0), 32'd1);
        checkOutput("t3_mosi_on_rises", 32'(a_rise_log), 32'h66);
        checkOutput("t3_sclk_rises", 32'(a_rises - r0), 32'd8);
        checkOutput("t3_rx_held", 32'(a_rx), 32'h66);

        $display("[TB] back-to-back 0xA5 then 0x5A");
        applyStimulus(1'b0, 8'hA5, 32'hA5, 37);
        waitDone(1'b0, 100);
        checkOutput("t4_cs_n_in_done_cycle", 32'(a_csn), 32'd1);
        applyStimulus(1'b0, 8'h5A, 32'h5A, 37);
        checkOutput("t4_cs_n_after_restart", 32'(a_csn), 32'd0);
        checkOutput("t4_busy_after_restart", 32'(a_busy), 32'd1);
        waitDone(1'b0, 100);

        $display("[TB] reset mid-transfer");
        applyStimulus(1'b0, 8'h33, 32'h33, 37);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t5_mosi_before_reset", 32'(a_mosi), 32'd1);
        #1;
        a_rst_n = 1'b0;
        #1;
        a_q.delete();
        checkOutput("t5_cs_n",    32'(a_csn),  32'd1);
        checkOutput("t5_sclk",    32'(a_sclk), 32'd0);
        checkOutput("t5_busy",    32'(a_busy), 32'd0);
        checkOutput("t5_mosi",    32'(a_mosi), 32'd0);
        checkOutput("t5_rx_data", 32'(a_rx),   32'd0);
        d0 = a_dones;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("t5_no_done", 32'(a_dones - d0), 32'd0);
        applyStimulus(1'b0, 8'h96, 32'h96, 37);
        waitDone(1'b0, 100);

        $display("[TB] CLK_DIV=1 DATA_WIDTH=4 loopback 0xC");
        applyStimulus(1'b1, 8'h0C, 32'hC, 11);
        prev = b_sclk;
        tog  = 0;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (b_sclk !== prev) tog = tog + 1;
            prev = b_sclk;
        end
        checkOutput("t6_sclk_toggles", 32'(tog), 32'd8);
        checkOutput("t6_cs_n_after_done", 32'(b_csn), 32'd1);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("a_pending_expected", 32'(a_q.size()), 32'd0);
        checkOutput("b_pending_expected", 32'(b_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
